pll_profile_manager: RTL and testbench

//   Multi-profile PLL reconfiguration sequencer, the parametrised successor to the single-shot reconfig glue.
//   It selects one of 2**PROFILE_W ROM profiles and drives the reconfig/busy handshake toward the reconfig engine.
//   It then pulses PLL areset and waits for lock, with a timeout and bounded retries.
//   It also filters lock loss and recovers from it automatically.
//   It sits between the top-level mode/resolution logic and the pll_reconf/pll_reconf_rom pair, in the control clock domain.

---
 rtl/pll_profile_manager.sv | 186 ++++++++++++++++++
 tb/tb_pll_profile_manager.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_profile_manager.sv
`default_nettype none
// ============================================================================
//  Module      : pll_profile_manager
//  Description : Multi-profile PLL reconfiguration sequencer with lock-wait,
//                bounded retries and filtered lock-loss recovery.
//  Revision    : 1.0  initial release
// ============================================================================
module pll_profile_manager #(
    parameter int PROFILE_W     = 8,
    parameter int AUTO_APPLY    = 1,
    parameter int ARESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int BUSY_TIMEOUT  = 1023,
    parameter int LOSS_FILTER   = 4,
    parameter int MAX_RETRIES   = 3,
    localparam int RETRY_W      = (MAX_RETRIES < 3) ? 2 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PROFILE_W-1:0] profile_sel,
    input  logic                 apply,
    input  logic                 pll_locked,
    input  logic                 reconf_busy,
    output logic                 reconf_start,
    output logic [PROFILE_W-1:0] rom_profile,
    output logic                 pll_areset,
    output logic                 ready,
    output logic                 error,
    output logic [PROFILE_W-1:0] active_profile,
    output logic [RETRY_W-1:0]   retry_count,
    output logic [7:0]           lockloss_count
);

    localparam int c_cnt_max0 = (LOCK_TIMEOUT > BUSY_TIMEOUT) ? LOCK_TIMEOUT : BUSY_TIMEOUT;
    localparam int c_cnt_max  = (c_cnt_max0 > ARESET_CYCLES) ? c_cnt_max0 : ARESET_CYCLES;
    localparam int CNT_W      = $clog2(c_cnt_max + 1);
    localparam int FILT_W     = $clog2(LOSS_FILTER + 1);

    localparam logic [CNT_W-1:0]   c_busy_last   = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_lock_last   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_areset_last = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [FILT_W-1:0]  c_filt_last   = FILT_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] c_max_retry   = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_BOOT      = 3'd0,
        S_START     = 3'd1,
        S_BUSY_HI   = 3'd2,
        S_BUSY_LO   = 3'd3,
        S_ARESET    = 3'd4,
        S_WAIT_LOCK = 3'd5,
        S_LOCKED    = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_sync;
    logic [CNT_W-1:0]     r_cnt;
    logic [FILT_W-1:0]    r_filt;
    logic [PROFILE_W-1:0] r_rom;
    logic [PROFILE_W-1:0] r_active;
    logic [RETRY_W-1:0]   r_retry;
    logic [7:0]           r_lockloss;
    logic                 r_pending;

    logic w_lock_sync;
    logic w_auto;
    logic w_req;
    logic w_req_any;
    logic w_in_flight;
    logic w_fail;
    logic w_lock_ok;
    logic w_loss;
    logic w_serve;

    assign w_lock_sync = r_sync[1];
    // Auto-apply compares against the targeted profile: it equals active_profile
    // in LOCKED, and in FAIL it keeps a failed profile from being retried forever.
    assign w_auto      = (AUTO_APPLY != 0) && (profile_sel != r_rom);
    assign w_req       = apply || w_auto;
    assign w_req_any   = w_req || r_pending;
    assign w_in_flight = (r_state != S_BOOT) && (r_state != S_LOCKED) && (r_state != S_FAIL);

    always_comb begin
        w_next    = r_state;
        w_fail    = 1'b0;
        w_lock_ok = 1'b0;
        w_loss    = 1'b0;
        w_serve   = 1'b0;
        case (r_state)
            S_BOOT:    w_next = S_START;
            S_START:   w_next = S_BUSY_HI;
            S_BUSY_HI: begin
                if (reconf_busy)               w_next = S_BUSY_LO;
                else if (r_cnt == c_busy_last) w_fail = 1'b1;
            end
            S_BUSY_LO: begin
                if (!reconf_busy)              w_next = S_ARESET;
                else if (r_cnt == c_busy_last) w_fail = 1'b1;
            end
            S_ARESET: begin
                if (r_cnt == c_areset_last)    w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_lock_sync && (r_filt == c_filt_last)) begin
                    w_lock_ok = 1'b1;
                    w_next    = S_LOCKED;
                end else if (r_cnt == c_lock_last) begin
                    w_fail = 1'b1;
                end
            end
            S_LOCKED: begin
                w_loss = !w_lock_sync && (r_filt == c_filt_last);
                if (w_req_any) begin
                    w_serve = 1'b1;
                    w_next  = S_START;
                end else if (w_loss) begin
                    w_next  = S_ARESET;
                end
            end
            S_FAIL: begin
                if (w_req_any) begin
                    w_serve = 1'b1;
                    w_next  = S_START;
                end
            end
            default:   w_next = S_BOOT;
        endcase
        if (w_fail) w_next = (r_retry < c_max_retry) ? S_START : S_FAIL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_sync     <= 2'b00;
            r_cnt      <= '0;
            r_filt     <= '0;
            r_rom      <= '0;
            r_active   <= '0;
            r_retry    <= '0;
            r_lockloss <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], pll_locked};
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;

            // Run length of synced lock while waiting, of synced unlock while locked
            if (w_next != r_state)                       r_filt <= '0;
            else if (r_state == S_WAIT_LOCK)             r_filt <= w_lock_sync ? r_filt + 1'b1 : '0;
            else if (r_state == S_LOCKED)                r_filt <= w_lock_sync ? '0 : r_filt + 1'b1;
            else                                         r_filt <= '0;

            if (r_state == S_BOOT) r_rom <= profile_sel;

            if (w_serve) begin
                r_rom     <= profile_sel;
                r_retry   <= '0;
                r_pending <= 1'b0;
            end else if (w_req && w_in_flight) begin
                r_pending <= 1'b1;
            end

            if (w_lock_ok) begin
                r_active <= r_rom;
                r_retry  <= '0;
            end

            if (w_fail && (r_retry < c_max_retry)) r_retry <= r_retry + 1'b1;

            if (w_loss && (r_lockloss != 8'hFF)) r_lockloss <= r_lockloss + 1'b1;
        end
    end

    assign reconf_start   = (r_state == S_START);
    assign pll_areset     = (r_state == S_BOOT) || (r_state == S_ARESET);
    assign ready          = (r_state == S_LOCKED);
    assign error          = (r_state == S_FAIL);
    assign rom_profile    = r_rom;
    assign active_profile = r_active;
    assign retry_count    = r_retry;
    assign lockloss_count = r_lockloss;

endmodule
`default_nettype wire

// File: tb/tb_pll_profile_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_profile_manager
//  Description : Self-checking bench with reconfig-engine and PLL models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_profile_manager;

    localparam int PW = 8;
    localparam int W_READY   = 0;
    localparam int W_UNREADY = 1;
    localparam int W_ERROR   = 2;
    localparam int W_AR_HI   = 3;
    localparam int W_AR_LO   = 4;
    localparam int W_BUSY    = 5;
    localparam int W_RETRY1  = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] profile_sel = '0;
    logic          apply = 1'b0;
    logic          pll_locked = 1'b0;
    logic          reconf_busy = 1'b0;
    logic          reconf_start;
    logic [PW-1:0] rom_profile;
    logic          pll_areset;
    logic          ready;
    logic          error;
    logic [PW-1:0] active_profile;
    logic [1:0]    retry_count;
    logic [7:0]    lockloss_count;

    always #5 clk = ~clk;

    pll_profile_manager #(
        .PROFILE_W    (PW),
        .AUTO_APPLY   (1),
        .ARESET_CYCLES(16),
        .LOCK_TIMEOUT (100),
        .BUSY_TIMEOUT (40),
        .LOSS_FILTER  (4),
        .MAX_RETRIES  (3)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .profile_sel   (profile_sel),
        .apply         (apply),
        .pll_locked    (pll_locked),
        .reconf_busy   (reconf_busy),
        .reconf_start  (reconf_start),
        .rom_profile   (rom_profile),
        .pll_areset    (pll_areset),
        .ready         (ready),
        .error         (error),
        .active_profile(active_profile),
        .retry_count   (retry_count),
        .lockloss_count(lockloss_count)
    );

    // Environment knobs (written by the stimulus) and model state (written by the model)
    int busy_mode = 1, busy_delay = 2, busy_len = 5;
    int lock_mode = 1, lock_delay = 20;
    int glitch_from = -1, glitch_to = -1;
    int cyc = 0, n_start = 0, eng_cnt = 0, ar_run = 0, last_ar_run = 0, lk_cnt = 0;
    bit eng_active = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reconfig engine answers each start pulse with a busy window; the PLL
    // drops lock while in reset and relocks lock_delay cycles after release.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (reconf_start) begin
            n_start++;
            eng_active = 1'b1;
            eng_cnt    = 0;
        end else if (eng_active) begin
            eng_cnt++;
        end
        if (eng_active && eng_cnt >= busy_delay + busy_len) eng_active = 1'b0;
        reconf_busy = (busy_mode != 0) && eng_active && (eng_cnt >= busy_delay);
        if (pll_areset) begin
            ar_run++;
            lk_cnt     = 0;
            pll_locked = 1'b0;
        end else begin
            if (ar_run > 0) begin
                last_ar_run = ar_run;
                ar_run      = 0;
            end
            lk_cnt++;
            pll_locked = (lock_mode != 0) && (lk_cnt >= lock_delay) &&
                         !(cyc >= glitch_from && cyc < glitch_to);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic bit cond_met(input int what);
        case (what)
            W_READY:   return ready === 1'b1;
            W_UNREADY: return ready === 1'b0;
            W_ERROR:   return error === 1'b1;
            W_AR_HI:   return pll_areset === 1'b1;
            W_AR_LO:   return pll_areset === 1'b0;
            W_BUSY:    return reconf_busy === 1'b1;
            W_RETRY1:  return retry_count === 2'd1;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int max_cycles);
        int k;
        k = 0;
        while (!cond_met(what) && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_start"},    32'(reconf_start),   32'd0);
        check({pfx, "_areset"},   32'(pll_areset),     32'd1);
        check({pfx, "_ready"},    32'(ready),          32'd0);
        check({pfx, "_error"},    32'(error),          32'd0);
        check({pfx, "_rom"},      32'(rom_profile),    32'd0);
        check({pfx, "_active"},   32'(active_profile), 32'd0);
        check({pfx, "_retry"},    32'(retry_count),    32'd0);
        check({pfx, "_lockloss"}, 32'(lockloss_count), 32'd0);
    endtask

    // Issue a request from LOCKED/FAIL, then step one cycle so the sequence is under way
    task automatic request(input logic [PW-1:0] p, input bit do_apply);
        profile_sel = p;
        apply       = do_apply;
        @(negedge clk);
        apply       = 1'b0;
    endtask

    initial begin
        int base;
        int exp_active;
        int exp_lockloss;
        bit stayed;
        logic [PW-1:0] p;

        exp_active   = 0;
        exp_lockloss = 0;

        // Power-up configuration to profile 3
        profile_sel = 8'd3;
        busy_delay  = int'($urandom_range(1, 8));
        busy_len    = 5;
        lock_delay  = 20;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        base  = n_start;
        reset = 1'b0;
        @(negedge clk);
        check("t1_start_pulse", 32'(reconf_start), 32'd1);
        check("t1_rom_loaded",  32'(rom_profile),  32'd3);
        @(negedge clk);
        check("t1_start_once",  32'(reconf_start), 32'd0);
        wait_for(W_READY, 400);
        exp_active = 3;
        check("t1_ready",       32'(ready),          32'd1);
        check("t1_starts",      32'(n_start - base), 32'd1);
        check("t1_active",      32'(active_profile), 32'(exp_active));
        check("t1_areset_len",  32'(last_ar_run),    32'd16);
        check("t1_error",       32'(error),          32'd0);

        // Auto-apply on a profile_sel change
        base = n_start;
        profile_sel = 8'd7;
        @(negedge clk);
        check("t2_start_next", 32'(reconf_start), 32'd1);
        wait_for(W_READY, 400);
        exp_active = 7;
        check("t2_ready",    32'(ready),          32'd1);
        check("t2_starts",   32'(n_start - base), 32'd1);
        check("t2_active",   32'(active_profile), 32'(exp_active));
        check("t2_lockloss", 32'(lockloss_count), 32'(exp_lockloss));

        // Randomized profile changes and timings
        for (int i = 0; i < 6; i++) begin
            bit ap;
            p          = PW'($urandom_range(0, 255));
            ap         = ($urandom_range(0, 1) == 1);
            if (int'(p) == exp_active) ap = 1'b1;
            busy_delay = int'($urandom_range(1, 8));
            busy_len   = int'($urandom_range(1, 30));
            lock_delay = int'($urandom_range(1, 40));
            base = n_start;
            request(p, ap);
            wait_for(W_READY, 400);
            exp_active = int'(p);
            check("rnd_ready",    32'(ready),          32'd1);
            check("rnd_starts",   32'(n_start - base), 32'd1);
            check("rnd_active",   32'(active_profile), 32'(exp_active));
            check("rnd_lockloss", 32'(lockloss_count), 32'(exp_lockloss));
        end

        // Lock glitch shorter than the filter is ignored
        base = n_start;
        glitch_from = cyc + 2;
        glitch_to   = glitch_from + 3;
        stayed = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ready !== 1'b1) stayed = 1'b0;
        end
        check("t4_short_ready",    32'(stayed),         32'd1);
        check("t4_short_lockloss", 32'(lockloss_count), 32'(exp_lockloss));

        // Filter-length loss: areset, relock, no new start pulse
        glitch_from = cyc + 2;
        glitch_to   = glitch_from + 4;
        wait_for(W_UNREADY, 30);
        check("t4_loss_seen", 32'(ready), 32'd0);
        wait_for(W_READY, 300);
        exp_lockloss++;
        check("t4_relock",      32'(ready),          32'd1);
        check("t4_lockloss",    32'(lockloss_count), 32'(exp_lockloss));
        check("t4_no_start",    32'(n_start - base), 32'd0);
        check("t4_areset_len",  32'(last_ar_run),    32'd16);
        check("t4_active",      32'(active_profile), 32'(exp_active));

        // Lock never rises: four attempts then FAIL
        lock_mode = 0;
        busy_len  = int'($urandom_range(1, 20));
        base = n_start;
        request(8'd5, 1'b1);
        wait_for(W_ERROR, 2000);
        check("t3_error",   32'(error),          32'd1);
        check("t3_starts",  32'(n_start - base), 32'd4);
        check("t3_retry",   32'(retry_count),    32'd3);
        check("t3_ready",   32'(ready),          32'd0);
        check("t3_areset",  32'(pll_areset),     32'd0);
        check("t3_active",  32'(active_profile), 32'(exp_active));
        repeat (10) @(negedge clk);
        check("t3_fail_held",   32'(error),          32'd1);
        check("t3_fail_starts", 32'(n_start - base), 32'd4);
        lock_mode = 1;
        lock_delay = int'($urandom_range(1, 40));
        request(8'd5, 1'b1);
        check("t3_err_clear",   32'(error),        32'd0);
        check("t3_restart",     32'(reconf_start), 32'd1);
        check("t3_retry_clear", 32'(retry_count),  32'd0);
        wait_for(W_READY, 400);
        exp_active = 5;
        check("t3_recover", 32'(active_profile), 32'(exp_active));

        // Request during WAIT_LOCK is held until the attempt locks
        base = n_start;
        request(8'd11, 1'b1);
        wait_for(W_AR_HI, 200);
        wait_for(W_AR_LO, 200);
        request(8'd9, 1'b1);
        wait_for(W_READY, 400);
        check("t5_first_active", 32'(active_profile), 32'd11);
        @(negedge clk);
        check("t5_pending_start", 32'(reconf_start), 32'd1);
        check("t5_pending_rom",   32'(rom_profile),  32'd9);
        wait_for(W_READY, 400);
        exp_active = 9;
        check("t5_active", 32'(active_profile), 32'(exp_active));
        check("t5_starts", 32'(n_start - base), 32'd2);

        // Lock-loss counter saturates at 255
        base = n_start;
        lock_delay = 1;
        stayed = 1'b1;
        for (int i = 0; i < 256; i++) begin
            glitch_from = cyc + 2;
            glitch_to   = glitch_from + 4;
            wait_for(W_UNREADY, 40);
            wait_for(W_READY, 200);
            if (ready !== 1'b1) stayed = 1'b0;
        end
        check("sat_relocked", 32'(stayed),         32'd1);
        check("sat_lockloss", 32'(lockloss_count), 32'd255);
        check("sat_no_start", 32'(n_start - base), 32'd0);

        // Reset mid WAIT_BUSY_LO, then busy never rises
        busy_delay = 2;
        busy_len   = 30;
        request(8'd12, 1'b1);
        wait_for(W_BUSY, 100);
        repeat (3) @(negedge clk);
        check("t6_in_busy", 32'(reconf_busy), 32'd1);
        busy_mode   = 0;
        profile_sel = 8'd14;
        reset       = 1'b1;
        @(negedge clk);
        check_reset_values("t6_rst");
        base  = n_start;
        reset = 1'b0;
        wait_for(W_RETRY1, 200);
        check("t6_retry1",  32'(retry_count),    32'd1);
        check("t6_starts2", 32'(n_start - base), 32'd2);
        check("t6_rom",     32'(rom_profile),    32'd14);
        wait_for(W_ERROR, 1000);
        check("t6_error",    32'(error),          32'd1);
        check("t6_starts4",  32'(n_start - base), 32'd4);
        check("t6_active",   32'(active_profile), 32'd0);
        check("t6_lockloss", 32'(lockloss_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
